axis_rr_arbiter: RTL and testbench
==================================

Name: axis_rr_arbiter

Overview:
- Packet-locked round-robin arbiter that multiplexes N AXI-Stream request/response sources onto one AXI-Stream link.
- Used in front of each axi2axis_XY router output so the local bridge and neighbour links share a single egress channel.
- Once a packet is granted, it stays granted until its TLAST beat, so flits of different packets never interleave.
- Output is registered: one beat of latency, full throughput.

Parameters:
- N_PORTS, 4, number of input streams (2..16).
- DATA_WIDTH, 40, TDATA width (equals AXIS_DATA_WIDTH).
- DEST_WIDTH, 4, TDEST width.
- SRC_WIDTH, $clog2(N_PORTS), width of the source-index output.

Ports:
- ACLK  in  1  clock, all state updates on the rising edge.
- ARESETn  in  1  asynchronous active-low reset.
- s_tvalid  in  N_PORTS  per-port TVALID.
- s_tready  out  N_PORTS  per-port TREADY.
- s_tdata  in  N_PORTS*DATA_WIDTH  per-port TDATA; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_tlast  in  N_PORTS  per-port TLAST.
- s_tdest  in  N_PORTS*DEST_WIDTH  per-port TDEST, packed the same way as s_tdata.
- m_tvalid  out  1  output TVALID.
- m_tready  in  1  output TREADY.
- m_tdata  out  DATA_WIDTH  output TDATA.
- m_tlast  out  1  output TLAST.
- m_tdest  out  DEST_WIDTH  output TDEST.
- m_tsrc  out  SRC_WIDTH  index of the input port that supplied the current output beat.
- busy  out  1  high while in LOCKED state (a multi-beat packet is in progress).

Behaviour:
- Reset (asynchronous, ARESETn=0):
  - m_tvalid, m_tdata, m_tlast, m_tdest, m_tsrc, busy all 0.
  - State = IDLE, round-robin pointer rr_ptr = 0, grant = 0.
  - s_tready = 0 while reset is asserted.
- Output-register free condition: out_free = !m_tvalid || m_tready.
- Accept on port i = s_tvalid[i] && s_tready[i].
  - On accept, the output register loads the beat on the next edge: data/last/dest, and m_tsrc = i.
  - If m_tvalid && m_tready and there is no accept, m_tvalid clears.
  - Output fields hold stable while m_tvalid && !m_tready (AXIS stability rule).
- State IDLE:
  - Candidate = first port with s_tvalid=1, searching circularly from rr_ptr (rr_ptr, rr_ptr+1, ... wrapping mod N_PORTS).
  - s_tready[candidate] = out_free; every other s_tready = 0.
  - No valid port: all s_tready = 0, state unchanged.
  - Accept with s_tlast=1 (single-beat packet): stay IDLE, rr_ptr = (candidate+1) mod N_PORTS.
  - Accept with s_tlast=0: go to LOCKED, grant = candidate.
- State LOCKED:
  - s_tready[grant] = out_free; all other s_tready = 0, regardless of their TVALID.
  - Accept with s_tlast=1: go to IDLE, rr_ptr = (grant+1) mod N_PORTS.
  - The granted port dropping TVALID mid-packet does not release the lock; the arbiter waits indefinitely.
- Latency and throughput:
  - Input accept to m_tvalid: 1 cycle.
  - Sustained rate of 1 beat/cycle while m_tready=1.
  - Back-to-back packets from different ports: no bubble, since the decision in IDLE is combinational in the same cycle.
- Rotation and fairness:
  - rr_ptr advances only at packet end, never on a stall or an idle cycle.
  - With all ports continuously valid, grants rotate 0,1,2,...,N-1,0.
  - Worst-case wait is N_PORTS-1 packets.
- s_tready must not depend combinationally on any s_tvalid other than through candidate selection in IDLE. No ready→valid loop back to the sources.
- m_tdest, m_tdata and m_tlast pass through unmodified; no width conversion.
- Mid-packet reset: the packet is discarded, the output is cleared, and arbitration restarts at port 0. Upstream is responsible for resynchronising.

Test Plan:
- Single packet, port 2, 3 beats (0x11, 0x22, 0x33 with last on the 3rd), m_tready=1:
  - m_tvalid is high for 3 consecutive cycles starting 1 cycle after the first accept.
  - m_tsrc=2 throughout; m_tlast only on 0x33; busy=1 for beats 1–2.
  - rr_ptr=3 afterwards.
- All 4 ports valid with 2-beat packets, m_tready=1:
  - Output order is port 0,0,1,1,2,2,3,3 with no idle cycle.
  - Pattern repeats from port 0.
- Port 1 locked with a 4-beat packet, port 0 valid throughout, port 1 drops TVALID for 3 cycles after beat 2:
  - s_tready[0] stays 0 and no port-0 beat appears until port 1's TLAST has transferred.
- Backpressure: m_tready=0 for 5 cycles with a beat held:
  - m_tdata, m_tlast and m_tsrc stay stable; all s_tready=0.
  - When m_tready rises, the next beat follows in the very next cycle.
- Single-beat packets on ports 3 and 0 alternating:
  - Grants go 3,0,3,0 with the pointer wrapping through 0; state never leaves IDLE; busy stays 0.
- ARESETn pulsed low while port 2 is mid-packet:
  - Outputs go to 0 immediately (asynchronously) and busy=0.
  - After release, a port-1 request is granted even though port 2 is still valid, because the pointer restarts at 0.

Source files
------------

// File: rtl/axis_rr_arbiter.sv
// Packet-locked round-robin AXI-Stream arbiter.
// N sources share one registered egress; packets never interleave.
module axis_rr_arbiter #(
  parameter int N_PORTS    = 4,
  parameter int DATA_WIDTH = 40,
  parameter int DEST_WIDTH = 4,
  parameter int SRC_WIDTH  = $clog2(N_PORTS)
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  input  logic [N_PORTS-1:0]           s_tvalid,
  output logic [N_PORTS-1:0]           s_tready,
  input  logic [N_PORTS*DATA_WIDTH-1:0] s_tdata,
  input  logic [N_PORTS-1:0]           s_tlast,
  input  logic [N_PORTS*DEST_WIDTH-1:0] s_tdest,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic [DATA_WIDTH-1:0]        m_tdata,
  output logic                         m_tlast,
  output logic [DEST_WIDTH-1:0]        m_tdest,
  output logic [SRC_WIDTH-1:0]         m_tsrc,
  output logic                         busy
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t state;

  logic [SRC_WIDTH-1:0]  rr_ptr;
  logic [SRC_WIDTH-1:0]  grant;
  logic [SRC_WIDTH-1:0]  cand;
  logic [SRC_WIDTH-1:0]  idx;
  logic [SRC_WIDTH-1:0]  sel;
  logic [SRC_WIDTH-1:0]  sel_nxt;
  logic                  cand_vld;
  logic                  sel_vld;
  logic                  out_free;
  logic                  accept;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic [DEST_WIDTH-1:0] in_dest;

  // Circular search for the first valid port starting at rr_ptr.
  always_comb begin
    cand     = '0;
    cand_vld = 1'b0;
    idx      = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      idx = SRC_WIDTH'((int'(rr_ptr) + k) % N_PORTS);
      if (!cand_vld && s_tvalid[idx]) begin
        cand_vld = 1'b1;
        cand     = idx;
      end
    end
  end

  // Selected port, its ready, the accept strobe and the input mux.
  always_comb begin
    sel      = (state == LOCKED) ? grant : cand;
    sel_vld  = (state == LOCKED) || cand_vld;
    out_free = !m_tvalid || m_tready;
    s_tready = '0;
    in_data  = '0;
    in_last  = 1'b0;
    in_dest  = '0;
    accept   = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (SRC_WIDTH'(i) == sel) begin
        in_data     = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        in_last     = s_tlast[i];
        in_dest     = s_tdest[i*DEST_WIDTH +: DEST_WIDTH];
        s_tready[i] = sel_vld && out_free && ARESETn;
        accept      = s_tready[i] && s_tvalid[i];
      end
    end
    if (sel == SRC_WIDTH'(N_PORTS - 1)) begin
      sel_nxt = '0;
    end else begin
      sel_nxt = sel + SRC_WIDTH'(1);
    end
  end

  // Arbitration FSM with registered output beat and busy flag.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      busy     <= 1'b0;
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
      m_tdest  <= '0;
      m_tsrc   <= '0;
    end else begin
      if (accept) begin
        m_tvalid <= 1'b1;
        m_tdata  <= in_data;
        m_tlast  <= in_last;
        m_tdest  <= in_dest;
        m_tsrc   <= sel;
        if (in_last) begin
          state  <= IDLE;
          busy   <= 1'b0;
          rr_ptr <= sel_nxt;
        end else begin
          state  <= LOCKED;
          busy   <= 1'b1;
          grant  <= sel;
        end
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: queued sources, transaction model,
// per-cycle compare and directed order/timing expectations.
module tb_axis_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 40;
  localparam int TW = 4;
  localparam int SW = 2;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic [N-1:0]  s_tvalid = '0;
  logic [N-1:0]  s_tready;
  logic [N*DW-1:0] s_tdata = '0;
  logic [N-1:0]  s_tlast = '0;
  logic [N*TW-1:0] s_tdest = '0;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic [TW-1:0] m_tdest;
  logic [SW-1:0] m_tsrc;
  logic          busy;

  axis_rr_arbiter #(
    .N_PORTS(N), .DATA_WIDTH(DW), .DEST_WIDTH(TW), .SRC_WIDTH(SW)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tdest(s_tdest),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tdest(m_tdest),
    .m_tsrc(m_tsrc), .busy(busy)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic          gap;
    logic [DW-1:0] data;
    logic          last;
    logic [TW-1:0] dest;
  } beat_t;

  typedef struct {
    int            src;
    logic [DW-1:0] data;
    logic          last;
    int            cyc;
  } ent_t;

  beat_t q [N][$];
  ent_t  log_q[$];
  logic [N-1:0] fire = '0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  // model state: lock owner (-1 none), rotation pointer, output slot
  int            md_owner;
  int            md_ptr;
  logic          md_v;
  logic [DW-1:0] md_d;
  logic          md_l;
  logic [TW-1:0] md_t;
  int            md_src;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int first_valid(int ptr, logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  always @(posedge ACLK) cyc <= cyc + 1;

  // Behavioural model: who gets served, what lands in the output slot.
  always @(posedge ACLK or negedge ARESETn) begin : model
    int p;
    logic free;
    if (!ARESETn) begin
      md_owner <= -1;
      md_ptr   <= 0;
      md_v     <= 1'b0;
      md_d     <= '0;
      md_l     <= 1'b0;
      md_t     <= '0;
      md_src   <= 0;
    end else begin
      free = !md_v || m_tready;
      p = (md_owner >= 0) ? md_owner : first_valid(md_ptr, s_tvalid);
      if (p >= 0 && free && s_tvalid[p]) begin
        md_v   <= 1'b1;
        md_d   <= s_tdata[p*DW +: DW];
        md_l   <= s_tlast[p];
        md_t   <= s_tdest[p*TW +: TW];
        md_src <= p;
        if (s_tlast[p]) begin
          md_owner <= -1;
          md_ptr   <= (p + 1) % N;
        end else begin
          md_owner <= p;
        end
      end else if (md_v && m_tready) begin
        md_v <= 1'b0;
      end
    end
  end

  // Per-cycle compare, transfer sampling and output logging.
  always @(negedge ACLK) begin : compare
    logic [N-1:0] er;
    int p;
    if (!ARESETn) begin
      chk("rst_s_tready", 64'(s_tready), 64'd0);
      chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      fire <= '0;
    end else begin
      er = '0;
      p = (md_owner >= 0) ? md_owner : first_valid(md_ptr, s_tvalid);
      if (p >= 0 && (!md_v || m_tready)) er[p] = 1'b1;
      chk("s_tready", 64'(s_tready), 64'(er));
      chk("m_tvalid", 64'(m_tvalid), 64'(md_v));
      chk("busy", 64'(busy), 64'(md_owner >= 0));
      if (md_v) begin
        chk("m_tdata", 64'(m_tdata), 64'(md_d));
        chk("m_tlast", 64'(m_tlast), 64'(md_l));
        chk("m_tdest", 64'(m_tdest), 64'(md_t));
        chk("m_tsrc", 64'(m_tsrc), 64'(md_src));
      end
      fire <= s_tvalid & s_tready;
      if (m_tvalid && m_tready)
        log_q.push_back('{int'(m_tsrc), m_tdata, m_tlast, cyc});
    end
  end

  // Source drivers: each port plays out its queue, gaps drop TVALID.
  always @(posedge ACLK) begin
    #1;
    for (int p = 0; p < N; p++) begin
      if (q[p].size() > 0 && (fire[p] || q[p][0].gap)) q[p].delete(0);
      if (q[p].size() > 0 && !q[p][0].gap) begin
        s_tvalid[p]         = 1'b1;
        s_tdata[p*DW +: DW] = q[p][0].data;
        s_tlast[p]          = q[p][0].last;
        s_tdest[p*TW +: TW] = q[p][0].dest;
      end else begin
        s_tvalid[p] = 1'b0;
        s_tlast[p]  = 1'b0;
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge ACLK);
    #3;
  endtask

  task automatic push(int p, logic [DW-1:0] d, logic l);
    q[p].push_back('{1'b0, d, l, 4'(p + 8)});
  endtask

  task automatic push_gap(int p);
    q[p].push_back('{1'b1, '0, 1'b0, 4'd0});
  endtask

  task automatic do_reset();
    ARESETn = 1'b0;
    tick(2);
    ARESETn = 1'b1;
    tick(1);
  endtask

  task automatic wait_log(int n, string name);
    int k;
    k = 0;
    while (log_q.size() < n && k < 200) begin
      @(posedge ACLK);
      k++;
    end
    #3;
    if (log_q.size() < n) begin
      checks++;
      errors++;
      $display("FAIL %s timeout beats=%0d required=%0d", name, log_q.size(), n);
    end
  endtask

  task automatic chk_ent(int i, string name, int src, logic [DW-1:0] d, logic l);
    if (i < log_q.size()) begin
      chk({name, "_src"}, 64'(log_q[i].src), 64'(src));
      chk({name, "_data"}, 64'(log_q[i].data), 64'(d));
      chk({name, "_last"}, 64'(log_q[i].last), 64'(l));
    end
  endtask

  initial begin
    #2;
    chk("reset_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("reset_m_tdata", 64'(m_tdata), 64'd0);
    chk("reset_m_tsrc", 64'(m_tsrc), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_s_tready", 64'(s_tready), 64'd0);
    tick(2);
    ARESETn = 1'b1;
    tick(1);

    // single 3-beat packet on port 2
    log_q.delete();
    push(2, 40'h11, 1'b0);
    push(2, 40'h22, 1'b0);
    push(2, 40'h33, 1'b1);
    wait_log(3, "p2_pkt");
    chk_ent(0, "p2_b0", 2, 40'h11, 1'b0);
    chk_ent(1, "p2_b1", 2, 40'h22, 1'b0);
    chk_ent(2, "p2_b2", 2, 40'h33, 1'b1);
    if (log_q.size() >= 3)
      chk("p2_contig", 64'(log_q[2].cyc - log_q[0].cyc), 64'd2);
    tick(2);
    // pointer now at 3: ports 0,1,3 together serve 3,0,1
    log_q.delete();
    push(0, 40'hF0, 1'b1);
    push(1, 40'hF1, 1'b1);
    push(3, 40'hF3, 1'b1);
    wait_log(3, "ptr3");
    chk_ent(0, "ptr3_a", 3, 40'hF3, 1'b1);
    chk_ent(1, "ptr3_b", 0, 40'hF0, 1'b1);
    chk_ent(2, "ptr3_c", 1, 40'hF1, 1'b1);
    tick(2);

    // all ports with two 2-beat packets each
    do_reset();
    log_q.delete();
    for (int p = 0; p < N; p++)
      for (int k = 0; k < 2; k++)
        for (int b = 0; b < 2; b++)
          push(p, 40'(p*16 + k*4 + b), 1'(b));
    wait_log(16, "rot");
    for (int i = 0; i < 16; i++) begin
      chk_ent(i, "rot", (i % 8) / 2,
              40'(((i % 8) / 2)*16 + (i / 8)*4 + (i % 2)), 1'(i % 2));
      if (i < log_q.size())
        chk("rot_contig", 64'(log_q[i].cyc - log_q[0].cyc), 64'(i));
    end
    tick(2);

    // port 1 locked across a TVALID gap while port 0 waits
    do_reset();
    log_q.delete();
    push(0, 40'hA0, 1'b1);
    wait_log(1, "lock_pre");
    tick(1);
    push(1, 40'hB1, 1'b0);
    push(1, 40'hB2, 1'b0);
    push_gap(1);
    push_gap(1);
    push_gap(1);
    push(1, 40'hB3, 1'b0);
    push(1, 40'hB4, 1'b1);
    push(0, 40'hA1, 1'b1);
    wait_log(6, "lock");
    chk_ent(1, "lock_b1", 1, 40'hB1, 1'b0);
    chk_ent(2, "lock_b2", 1, 40'hB2, 1'b0);
    chk_ent(3, "lock_b3", 1, 40'hB3, 1'b0);
    chk_ent(4, "lock_b4", 1, 40'hB4, 1'b1);
    chk_ent(5, "lock_a1", 0, 40'hA1, 1'b1);
    tick(2);

    // backpressure on a held beat
    log_q.delete();
    m_tready = 1'b0;
    push(2, 40'hC1, 1'b0);
    push(2, 40'hC2, 1'b0);
    push(2, 40'hC3, 1'b1);
    tick(2);
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("bp_tvalid", 64'(m_tvalid), 64'd1);
      chk("bp_tdata", 64'(m_tdata), 64'hC1);
      chk("bp_tlast", 64'(m_tlast), 64'd0);
      chk("bp_tsrc", 64'(m_tsrc), 64'd2);
      chk("bp_s_tready", 64'(s_tready), 64'd0);
      tick(1);
    end
    m_tready = 1'b1;
    wait_log(3, "bp");
    chk_ent(0, "bp_c1", 2, 40'hC1, 1'b0);
    chk_ent(1, "bp_c2", 2, 40'hC2, 1'b0);
    chk_ent(2, "bp_c3", 2, 40'hC3, 1'b1);
    if (log_q.size() >= 3)
      chk("bp_contig", 64'(log_q[2].cyc - log_q[0].cyc), 64'd2);
    tick(2);

    // single-beat packets on ports 3 and 0, pointer at 3
    log_q.delete();
    push(3, 40'hD0, 1'b1);
    push(3, 40'hD1, 1'b1);
    push(0, 40'hE0, 1'b1);
    push(0, 40'hE1, 1'b1);
    wait_log(4, "alt");
    chk_ent(0, "alt_0", 3, 40'hD0, 1'b1);
    chk_ent(1, "alt_1", 0, 40'hE0, 1'b1);
    chk_ent(2, "alt_2", 3, 40'hD1, 1'b1);
    chk_ent(3, "alt_3", 0, 40'hE1, 1'b1);
    tick(2);

    // reset in the middle of a port-2 packet
    log_q.delete();
    for (int b = 0; b < 5; b++) push(2, 40'(8'h90 + b), 1'(b == 4));
    wait_log(2, "mid_pre");
    ARESETn = 1'b0;
    #1;
    chk("mid_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("mid_m_tdata", 64'(m_tdata), 64'd0);
    chk("mid_m_tsrc", 64'(m_tsrc), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_s_tready", 64'(s_tready), 64'd0);
    push(1, 40'h77, 1'b1);
    tick(2);
    ARESETn = 1'b1;
    log_q.delete();
    wait_log(1, "mid_post");
    chk_ent(0, "mid_p1", 1, 40'h77, 1'b1);
    tick(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
